// File: rtl/axi_lite_rd_arbiter.sv
// Two-master, one-slave AXI4-Lite read-channel arbiter (IFU = m0, LSU = m1).
// One read in flight; round-robin on ties; grant held from AR accept to R accept.
module axi_lite_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic [1:0]        gnt
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e     state_q, state_d;
  logic       gnt_id_q, gnt_id_d;
  logic       last_id_q, last_id_d;
  logic [1:0] gnt_q, gnt_d;

  logic in_addr, in_data;
  assign in_addr = (state_q == ADDR);
  assign in_data = (state_q == DATA);

  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    last_id_d = last_id_q;
    gnt_d     = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          // Tie goes to whoever did not win last; last_id resets to 1 so m0 wins first.
          if (m0_arvalid && m1_arvalid) gnt_id_d = ~last_id_q;
          else                          gnt_id_d = m1_arvalid;
          gnt_d   = gnt_id_d ? 2'b10 : 2'b01;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (s_arvalid && s_arready) state_d = DATA;
      end
      DATA: begin
        if (s_rvalid && s_rready) begin
          last_id_d = gnt_id_q;
          gnt_d     = 2'b00;
          state_d   = IDLE;
        end
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_id_q  <= 1'b0;
      last_id_q <= 1'b1;
      gnt_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      last_id_q <= last_id_d;
      gnt_q     <= gnt_d;
    end
  end

  // Address and response paths are steered combinationally by the held grant.
  assign s_araddr   = (in_addr && gnt_id_q) ? m1_araddr : m0_araddr;
  assign s_arvalid  = in_addr && (gnt_id_q ? m1_arvalid : m0_arvalid);
  assign m0_arready = in_addr && !gnt_id_q && s_arready;
  assign m1_arready = in_addr &&  gnt_id_q && s_arready;

  assign s_rready   = in_data && (gnt_id_q ? m1_rready : m0_rready);
  assign m0_rvalid  = in_data && !gnt_id_q && s_rvalid;
  assign m1_rvalid  = in_data &&  gnt_id_q && s_rvalid;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;
  assign m0_rresp   = s_rresp;
  assign m1_rresp   = s_rresp;

  assign gnt = gnt_q;

endmodule

// File: doc/axi_lite_rd_arbiter.md
Name: axi_lite_rd_arbiter

Overview:
- Two-master, one-slave AXI4-Lite read-channel (AR/R) arbiter. It lets the IFU (master 0) and the LSU (master 1) share the single memory read port.
- The AW/W/B write channels bypass this block; the LSU drives them to the slave directly.
- At most one read is outstanding at a time. Ties are broken round-robin. A grant is held from AR handshake through R handshake.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, read data width

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
m0_araddr  input  ADDR_W  IFU read address
m0_arvalid  input  1  IFU AR valid
m0_arready  output  1  IFU AR ready
m0_rdata  output  DATA_W  IFU read data
m0_rresp  output  2  IFU read response
m0_rvalid  output  1  IFU R valid
m0_rready  input  1  IFU R ready
m1_araddr  input  ADDR_W  LSU read address
m1_arvalid  input  1  LSU AR valid
m1_arready  output  1  LSU AR ready
m1_rdata  output  DATA_W  LSU read data
m1_rresp  output  2  LSU read response
m1_rvalid  output  1  LSU R valid
m1_rready  input  1  LSU R ready
s_araddr  output  ADDR_W  slave read address
s_arvalid  output  1  slave AR valid
s_arready  input  1  slave AR ready
s_rdata  input  DATA_W  slave read data
s_rresp  input  2  slave read response
s_rvalid  input  1  slave R valid
s_rready  output  1  slave R ready
gnt  output  2  one-hot current grant {m1,m0}; 0 when idle

Behaviour:
- Registered state: FSM {IDLE, ADDR, DATA}, gnt_id (1 bit), last_id (1 bit).
- Reset (rst=1 at posedge):
  - state=IDLE, last_id=1, gnt=0.
  - All valid/ready outputs (m*_arready, m*_rvalid, s_arvalid, s_rready) are 0 while state=IDLE.
- m0_rdata/m1_rdata = s_rdata and m0_rresp/m1_rresp = s_rresp unconditionally; only rvalid qualifies them.
- IDLE:
  - No arvalid: stay.
  - Exactly one arvalid: gnt_id = that master.
  - Both arvalid: gnt_id = ~last_id (first tie after reset goes to m0).
  - Any arvalid moves the FSM to ADDR. Outputs are all 0 in IDLE, so there is 1 cycle of arbitration latency.
- ADDR:
  - s_araddr = m[gnt_id]_araddr; s_arvalid = m[gnt_id]_arvalid.
  - m[gnt_id]_arready = s_arready; the other master's arready = 0.
  - On s_arvalid & s_arready: go to DATA.
  - If the granted master drops arvalid (protocol violation), stay in ADDR; the grant is not revoked.
- DATA:
  - s_arvalid = 0; m[gnt_id]_rvalid = s_rvalid; the other master's rvalid = 0; s_rready = m[gnt_id]_rready.
  - On s_rvalid & s_rready: last_id <= gnt_id; go to IDLE.
- s_araddr in IDLE/DATA = m0_araddr (don't-care; no valid asserted).
- gnt = one-hot(gnt_id) in ADDR and DATA, 0 in IDLE.
- A request from the non-granted master during ADDR/DATA waits with arready=0. It is considered in the IDLE cycle after the R handshake.
- No back-to-back bypass: minimum cost is 1 idle cycle per transaction, so best case is 3 cycles per read with a zero-wait slave.
- Reset mid-transaction: the FSM returns to IDLE at that edge and all valid/ready outputs drop. The slave shares rst and is expected to abandon its in-flight response.
- Any rresp value (including SLVERR/DECERR) is forwarded unchanged and ends the transaction.

Test Plan:
- IFU single read, slave ready immediately, rvalid 2 cycles after AR with rdata=0x00000413, rresp=0. Required: m0_arready high 1 cycle after m0_arvalid; m0_rvalid with 0x00000413; m1_rvalid stays 0; gnt=01 during ADDR/DATA.
- Both arvalid held continuously after reset, addrs 0x80000000/0x80001000. Required: slave sees addresses in order m0,m1,m0,m1 (round-robin); each grant completes its R before the next AR.
- m1_arvalid raised while m0 is in DATA. Required: m1_arready=0 until m0's R handshake; m1 AR issued 1 cycle after returning to IDLE.
- s_arready held low 5 cycles with m0 granted and m1 also requesting. Required: s_araddr stays m0's address; gnt stays 01; no switch to m1.
- m1 read, s_rvalid=1 but m1_rready=0 for 3 cycles, rresp=2'b10. Required: s_rready=0 for those cycles; handshake on the cycle m1_rready=1; m1_rresp=2'b10.
- rst pulsed 1 cycle while in DATA for m1. Required: next cycle all valid/ready=0 and gnt=0; the next simultaneous request is granted to m0.
